// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump engine:
// geometry defaults and FSM state encoding.
package regfile_dump_pkg;

  localparam int RF_NUM_REGS = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready word stream out of the dump engine.
// master drives valid/addr/data/last, slave drives ready.
interface regfile_dump_if
  import regfile_dump_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) ();

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (
    output valid,
    output addr,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  addr,
    input  data,
    input  last,
    output ready
  );

endinterface

// File: rtl/regfile_dump.sv
// Sweeps a register file and streams {addr,data} words out.
// Ports: clk, rst_n, start, skip_zero, abort, rf_raddr/rf_rdata, dump stream, busy, done.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               skip_zero,
  input  logic               abort,
  output logic [ADDR_W-1:0]  rf_raddr,
  input  logic [DATA_W-1:0]  rf_rdata,
  regfile_dump_if.master     dump,
  output logic               busy,
  output logic               done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;

  // idx is a register, so the read port never glitches
  assign rf_raddr   = idx;
  assign dump.valid = valid_q;
  assign dump.addr  = addr_q;
  assign dump.data  = data_q;
  assign dump.last  = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state != IDLE && abort) begin
        // abort wins over a same-cycle acceptance
        state   <= IDLE;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              idx    <= skip_zero ? ADDR_W'(1) : '0;
              state  <= READ;
              busy_q <= 1'b1;
            end
          end
          READ: begin
            data_q  <= rf_rdata;
            addr_q  <= idx;
            last_q  <= (idx == LAST);
            valid_q <= 1'b1;
            state   <= SEND;
          end
          SEND: begin
            if (dump.ready) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              if (idx == LAST) begin
                state  <= DONE;
                done_q <= 1'b1;
              end else begin
                idx   <= idx + 1'b1;
                state <= READ;
              end
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: table of sweep scenarios
// plus hand sequences for reset and abort/start collisions.
module tb_regfile_dump;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        skip_zero;
  logic        abort;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];

  int errors;
  int checks;
  int done_seen;

  regfile_dump_if dif ();

  regfile_dump dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .skip_zero (skip_zero),
    .abort     (abort),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .dump      (dif),
    .busy      (busy),
    .done      (done)
  );

  assign rf_rdata = rf[rf_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_seen++;

  typedef struct {
    bit skip;
    int stall_at;
    int abort_at;
    int restart_at;
    int rst_at;
  } scen_t;

  scen_t tbl [6];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(string nm);
    chk({nm, " valid"}, 64'(dif.valid), 0);
    chk({nm, " addr"}, 64'(dif.addr), 0);
    chk({nm, " data"}, 64'(dif.data), 0);
    chk({nm, " last"}, 64'(dif.last), 0);
    chk({nm, " busy"}, 64'(busy), 0);
    chk({nm, " done"}, 64'(done), 0);
    chk({nm, " raddr"}, 64'(rf_raddr), 0);
  endtask

  task automatic sweep(input scen_t s);
    int w;
    int d0;
    int first;
    first = s.skip ? 1 : 0;
    dif.ready = 1'b1;
    start = 1'b1;
    skip_zero = s.skip;
    @(negedge clk);
    start = 1'b0;
    skip_zero = 1'b0;
    chk("busy after start", 64'(busy), 1);
    for (int a = first; a < 32; a++) begin
      w = 0;
      while (!dif.valid && w < 10) begin
        @(negedge clk);
        w++;
      end
      if (!dif.valid) begin
        chk($sformatf("timeout addr %0d", a), 0, 1);
        return;
      end
      chk($sformatf("gap addr %0d", a), 64'(w), 1);
      chk($sformatf("addr %0d", a), 64'(dif.addr), 64'(a));
      chk($sformatf("data %0d", a), 64'(dif.data), 64'(10 * a));
      chk($sformatf("last %0d", a), 64'(dif.last), 64'(a == 31));
      chk($sformatf("raddr %0d", a), 64'(rf_raddr), 64'(a));
      if (a == s.stall_at) begin
        dif.ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall valid", 64'(dif.valid), 1);
          chk("stall data", 64'(dif.data), 64'(10 * a));
          chk("stall addr", 64'(dif.addr), 64'(a));
        end
        dif.ready = 1'b1;
      end
      if (a == s.restart_at) begin
        start = 1'b1;
      end
      if (a == s.abort_at) begin
        d0 = done_seen;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort valid", 64'(dif.valid), 0);
        chk("abort busy", 64'(busy), 0);
        repeat (3) @(negedge clk);
        chk("abort still idle", 64'(busy), 0);
        chk("abort no done", 64'(done_seen), 64'(d0));
        return;
      end
      if (a == s.rst_at) begin
        d0 = done_seen;
        #2 rst_n = 1'b0;
        #1 chk_idle_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst no done", 64'(done_seen), 64'(d0));
        chk("rst idle", 64'(busy), 0);
        return;
      end
      @(negedge clk);
      start = 1'b0;
      if (a == 31) begin
        chk("done pulse", 64'(done), 1);
        chk("done busy", 64'(busy), 1);
        chk("done valid", 64'(dif.valid), 0);
        @(negedge clk);
        chk("done cleared", 64'(done), 0);
        chk("idle busy", 64'(busy), 0);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    done_seen = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(10 * i);
    tbl[0] = '{0, -1, -1, -1, -1};
    tbl[1] = '{1, -1, -1, -1, -1};
    tbl[2] = '{0,  3, -1, -1, -1};
    tbl[3] = '{0, -1,  7, -1, -1};
    tbl[4] = '{0, -1, -1, -1, -1};
    tbl[5] = '{0, -1, -1,  5, 12};

    rst_n = 1'b0;
    start = 1'b0;
    skip_zero = 1'b0;
    abort = 1'b0;
    dif.ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post reset busy", 64'(busy), 0);

    // start and abort together in IDLE stays idle
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start+abort busy", 64'(busy), 0);
    @(negedge clk);
    chk("start+abort valid", 64'(dif.valid), 0);

    for (int k = 0; k < 6; k++) begin
      sweep(tbl[k]);
      @(negedge clk);
    end

    chk("total done pulses", 64'(done_seen), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 32, giving the number of registers swept.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the register-address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, giving the register-data width.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset.
REQ-005 clk  input  1  Clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  Asynchronous active-low reset.
REQ-007 start  input  1  Single-cycle pulse requesting a full sweep; sampled only in IDLE.
REQ-008 skip_zero  input  1  Sampled with start; 1 begins the sweep at register 1.
REQ-009 abort  input  1  Terminates any sweep in progress.
REQ-010 rf_raddr  output  ADDR_W  Read address to the register-file read port.
REQ-011 rf_rdata  input  DATA_W  Combinational read data for rf_raddr.
REQ-012 out_valid  output  1  Output word valid.
REQ-013 out_ready  input  1  Consumer accepts the word when high together with out_valid.
REQ-014 out_addr  output  ADDR_W  Register index of the current word.
REQ-015 out_data  output  DATA_W  Registered register contents.
REQ-016 out_last  output  1  High with out_valid on the word for index NUM_REGS-1.
REQ-017 busy  output  1  High in every state except IDLE.
REQ-018 done  output  1  One-cycle pulse after the last word is accepted.

Function
REQ-019 The FSM SHALL have four states: IDLE, READ, SEND, and DONE.
REQ-020 In IDLE, start=1 SHALL load idx (0, or 1 when skip_zero=1) and move the FSM to READ; start SHALL be ignored in every other state.
REQ-021 In READ, rf_raddr SHALL equal idx, and on the next edge rf_rdata SHALL be captured into out_data, idx into out_addr, and the FSM SHALL move to SEND.
REQ-022 In SEND, out_valid SHALL be 1, and out_data, out_addr, and out_last SHALL remain stable until out_valid&&out_ready.
REQ-023 On acceptance, when idx==NUM_REGS-1 the FSM SHALL move to DONE; otherwise idx SHALL increment and the FSM SHALL move to READ.
REQ-024 DONE SHALL assert done for exactly one cycle and then return the FSM to IDLE.
REQ-025 Latency from the start edge to the first out_valid SHALL be 2 cycles, and sustained throughput SHALL be one word per 2 cycles when out_ready=1.
REQ-026 idx SHALL never wrap; no word beyond NUM_REGS-1 SHALL be emitted.
REQ-027 abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge, with out_valid=0 and no done pulse.
REQ-028 abort SHALL take priority over acceptance in the same cycle, so that word is not counted as accepted.
REQ-029 abort and start together in IDLE SHALL leave the FSM in IDLE.
REQ-030 rf_raddr SHALL hold idx in all states, for a glitch-free read port.

Reset
REQ-031 While rst_n=0, the FSM SHALL be IDLE, idx=0, and rf_raddr, out_addr, and out_data SHALL all be 0.
REQ-032 While rst_n=0, out_valid, out_last, busy, and done SHALL all be 0.
REQ-033 Reset asserted mid-sweep SHALL drop out_valid immediately (asynchronously), and no done SHALL follow.

Structure
REQ-034 The state encodings, NUM_REGS, ADDR_W, and DATA_W SHALL reside in the shared processor definitions package/include.
REQ-035 The design SHALL be a single module with no sub-modules; the index counter SHALL be inline.

Verification
REQ-036 Reset, then start with skip_zero=0 and out_ready=1, on a register file preloaded with reg[i]=10*i -> 32 words at addr 0..31 with data 0,10,...,310, out_last only on addr 31, and done 1 cycle after that acceptance.
REQ-037 start with skip_zero=1 -> first word is addr 1 with data 10, and 31 words in total.
REQ-038 Hold out_ready=0 for 5 cycles on word addr 3 -> out_valid stays 1, out_data stays 30 throughout, then the sweep resumes with no word lost or duplicated.
REQ-039 abort pulsed while SEND is at addr 7 with out_ready=1 -> out_valid=0 next cycle, FSM IDLE, no done; a new start then begins again at addr 0.
REQ-040 start pulsed again while busy, and rst_n dropped at addr 12 -> the second start has no effect; on reset all outputs are 0 immediately and busy=0.
